// File: rtl/sram_stream_reader_pkg.sv
// Shared constants, sizing helper and FSM encoding for the SRAM stream reader.
package sram_stream_reader_pkg;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  localparam int NB_DATA = 8192;
  localparam int L_DATA  = 16;
  localparam int L_ADDR  = clogb2(NB_DATA);
  localparam int L_LEN   = L_ADDR + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sram_stream_reader_fifo.sv
// Two-entry fall-through FIFO: an empty FIFO passes the incoming word straight to
// the output, so a consumer that keeps up sees one beat per cycle.
module stream_skid_fifo2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         empty, pop, wr_en, rd_en;

  always_comb begin
    empty     = (count_q == 2'd0);
    out_valid = !empty || in_valid;
    out_data  = empty ? (in_valid ? in_data : '0) : mem_q[rd_ptr_q];
    pop       = out_valid && out_ready;
    // A word arriving while empty and immediately accepted never lands in storage.
    wr_en     = in_valid && !(empty && out_ready);
    rd_en     = pop && !empty;
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (rd_en) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, wr_en} - {1'b0, rd_en};
    count   = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_stream_reader.sv
// Burst reader: issues sequential SRAM reads and returns the words as a
// valid/ready stream, throttled so returning data always has a FIFO slot.
module sram_stream_reader
  import sram_stream_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [L_ADDR-1:0] cmd_base_addr,
  input  logic [L_LEN-1:0]  cmd_len,
  output logic              rEn,
  output logic [L_ADDR-1:0] rAddr,
  input  logic [L_DATA-1:0] rData,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [L_DATA-1:0] out_data,
  output logic              out_last,
  output logic              done
);

  // Stream handshake: a beat transfers on a rising edge where out_valid and
  // out_ready are both 1; while out_valid=1 and out_ready=0 the beat is held.

  state_t            state_q, state_d;
  logic [L_ADDR-1:0] addr_q, addr_d;
  logic [L_LEN-1:0]  len_q, len_d;
  logic [L_LEN-1:0]  issued_q, issued_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic              done_q, done_d;
  logic              issue;
  logic [L_LEN-1:0]  len_clamped;
  logic [1:0]        fifo_count;
  logic [1:0]        credit_used;
  logic [L_DATA:0]   fifo_out;

  stream_skid_fifo2 #(.W(L_DATA + 1)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inflight_q),
    .in_data  ({inflight_last_q, rData}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (fifo_out),
    .count    (fifo_count)
  );

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    len_d           = len_q;
    issued_d        = issued_q;
    done_d          = 1'b0;
    issue           = 1'b0;
    len_clamped     = (cmd_len > L_LEN'(NB_DATA)) ? L_LEN'(NB_DATA) : cmd_len;
    credit_used     = fifo_count + {1'b0, inflight_q};
    cmd_ready       = (state_q == ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_base_addr;
          len_d    = len_clamped;
          issued_d = '0;
          if (len_clamped == '0) done_d = 1'b1;
          else                   state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        issue = (issued_q < len_q) && (credit_used < 2'd2);
        if (issue) begin
          issued_d = issued_q + L_LEN'(1);
          addr_d   = addr_q + L_ADDR'(1);
          if (issued_q == len_q - L_LEN'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_valid && out_ready && out_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    inflight_d      = issue;
    inflight_last_d = issue && (issued_q == len_q - L_LEN'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  assign rEn      = ~issue;
  assign rAddr    = addr_q;
  assign out_data = fifo_out[L_DATA-1:0];
  assign out_last = fifo_out[L_DATA];
  assign done     = done_q;

endmodule

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
- Read-side client for the banked 8192x16 SRAM macro wrapper.
- Accepts a burst command (base address, length) and issues sequential reads on the SRAM read port.
- Absorbs the fixed 1-cycle SRAM read latency and returns the data as a valid/ready stream with last-beat marking.
- Sits between the buffer SRAMs and the PE-array feeders, so a stalled consumer never loses SRAM data.

Parameters:
- nb_data, 8192, SRAM depth in words.
- L_data, 16, data width in bits.
- L_addr, clogb2(nb_data) = 13, address width.
- L_len, L_addr+1 = 14, burst-length width; allows lengths 0..nb_data.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  block idle and able to accept a command.
- cmd_base_addr  input  L_addr  first word address.
- cmd_len  input  L_len  number of words to read.
- rEn  output  1  SRAM read enable, active-low (0 = read this cycle).
- rAddr  output  L_addr  SRAM read address.
- rData  input  L_data  SRAM read data; valid the cycle after rEn=0.
- out_valid  output  1  stream data valid.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  L_data  stream data.
- out_last  output  1  final beat of the burst.
- done  output  1  one-cycle pulse after the final beat is accepted, or after a zero-length command is accepted.

Behaviour:
- Reset values:
  - cmd_ready=1, rEn=1, rAddr=0, out_valid=0, out_last=0, out_data=0, done=0.
  - FSM=IDLE, FIFO empty, counters 0.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch base/len.
    - len=0: pulse done next cycle, stay in IDLE.
    - Otherwise go to RUN.
  - RUN: cmd_ready=0. Issue reads while issued<len and credit is available. When all reads are issued, go to DRAIN.
  - DRAIN: no new reads. When the last beat handshakes (out_valid&out_ready&out_last), pulse done and return to IDLE.
- Read issue rule:
  - rEn=0 only if (fifo_count + inflight) < 2, where inflight = read issued in the previous cycle.
  - This guarantees every returned word has a slot, with no overflow under any out_ready pattern.
- Address handling:
  - rAddr = base + issued_count, modulo nb_data; wraps 8191 -> 0.
  - rAddr is driven from a registered counter and held when rEn=1.
- Return path:
  - Capture rData into a 2-entry FIFO exactly one cycle after the read was issued.
  - The FIFO head drives out_data/out_valid.
  - out_last is asserted with the beat whose ordinal equals len-1; it is carried as a FIFO side bit.
- Throughput: with out_ready held at 1, one beat per cycle after a 2-cycle start.
  - Command accept at cycle 0 -> first rEn=0 at cycle 1 -> first out_valid at cycle 2.
- Stream rule: out_data/out_last are stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop on the FIFO in one cycle is legal; occupancy is unchanged.
- cmd_valid during RUN/DRAIN is ignored (cmd_ready=0); nothing is latched.
- cmd_len > nb_data is clamped to nb_data.
- Reset mid-burst: the next cycle returns to reset values.
  - Any in-flight SRAM data is discarded.
  - No done pulse is produced.
  - The block never writes to the SRAM.

Decomposition:
- Shared package: clogb2 function, SRAM depth/width constants (8192, 16), FSM state encoding (IDLE/RUN/DRAIN).
- Sub-module: stream_skid_fifo2, a 2-entry valid/ready FIFO carrying {last, data} and exposing a count output for the credit check.

Test Plan:
1. base=0x0010, len=4, out_ready=1 -> rEn low cycles 1-4, rAddr 0x10..0x13; out beats cycles 2-5 matching preloaded words; out_last on beat 3; done at cycle 6.
2. base=0x1FFE, len=4 -> rAddr sequence 0x1FFE, 0x1FFF, 0x0000, 0x0001; data order preserved across the bank boundary.
3. len=16, out_ready random 30% duty -> all 16 words delivered in order, none dropped or duplicated; inflight+count never exceeds 2; data stable during stalls.
4. len=0 -> no rEn=0 and no out_valid; done pulses the cycle after the handshake; cmd_ready stays 1.
5. rst asserted at beat 5 of a len=10 burst -> next cycle out_valid=0, rEn=1, cmd_ready=1, no done; a following len=2 command completes normally.
6. cmd_valid held high throughout a len=8 burst -> exactly one command accepted; a second accepted only after done.
